mem_access: RTL

- Memory stage of the RV32I pipeline, directly downstream of the execute stage.
- Consumes the execute stage's destination register, write enable and 32-bit ALU result. For loads and stores, that result is the effective address.
- Runs a req/ack data-memory transaction with byte-lane steering, sign/zero extension, misalignment detection and a bus timeout.
- Stalls upstream while a transaction is outstanding and delivers registered writeback data to the next stage.

---
 rtl/mem_access.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// RV32I memory stage: issues req/ack data-memory transactions with byte-lane steering,
// load extension, misalignment checks and a bus timeout, and registers writeback results.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  mem_op_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        err_o
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0]  cap_wd_q, cap_wd_d;
    logic        cap_wreg_q, cap_wreg_d;
    logic        cap_load_q, cap_load_d;
    logic [2:0]  cap_f3_q, cap_f3_d;
    logic [1:0]  cap_off_q, cap_off_d;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic        valid_q, valid_d;
    logic [4:0]  wd_q, wd_d;
    logic        wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic        is_load, is_store, f3_legal, aligned;
    logic [3:0]  be_calc;
    logic [31:0] st_calc;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Decode the incoming instruction's width, legality, lanes and store data.
    always_comb begin
        is_load  = (mem_op_i == 2'b01);
        is_store = (mem_op_i == 2'b10);
        f3_legal = 1'b0;
        if (is_load) begin
            f3_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                       (funct3_i == 3'b100) || (funct3_i == 3'b101);
        end else if (is_store) begin
            f3_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
        end
        case (funct3_i[1:0])
            2'b01:   aligned = ~wdata_i[0];
            2'b10:   aligned = (wdata_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        be_calc = 4'b1111;
        st_calc = store_data_i;
        if (is_store) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_calc = 4'b0001 << wdata_i[1:0];
                    st_calc = {4{store_data_i[7:0]}};
                end
                2'b01: begin
                    be_calc = wdata_i[1] ? 4'b1100 : 4'b0011;
                    st_calc = {2{store_data_i[15:0]}};
                end
                default: begin
                    be_calc = 4'b1111;
                    st_calc = store_data_i;
                end
            endcase
        end
    end

    // Select and extend the addressed lane of the returned read word.
    always_comb begin
        case (cap_off_q)
            2'd0:    ld_byte = dmem_rdata_i[7:0];
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = cap_off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (cap_f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_wd_d   = cap_wd_q;
        cap_wreg_d = cap_wreg_q;
        cap_load_d = cap_load_q;
        cap_f3_d   = cap_f3_q;
        cap_off_d  = cap_off_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        mwdata_d   = mwdata_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (is_load || is_store) begin
                        if (!f3_legal || !aligned) begin
                            valid_d = 1'b1;
                            err_d   = 1'b1;
                            wd_d    = wd_i;
                            wreg_d  = 1'b0;
                            wdata_d = 32'b0;
                        end else begin
                            cap_wd_d   = wd_i;
                            cap_wreg_d = wreg_i;
                            cap_load_d = is_load;
                            cap_f3_d   = funct3_i;
                            cap_off_d  = wdata_i[1:0];
                            req_d      = 1'b1;
                            we_d       = is_store;
                            addr_d     = {wdata_i[31:2], 2'b00};
                            be_d       = be_calc;
                            mwdata_d   = st_calc;
                            cnt_d      = '0;
                            state_d    = ST_WAIT;
                        end
                    end else begin
                        valid_d = 1'b1;
                        wd_d    = wd_i;
                        wreg_d  = wreg_i;
                        wdata_d = wdata_i;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                // Ack takes priority over a timeout landing in the same cycle.
                if (dmem_ack_i) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    wd_d    = cap_wd_q;
                    wreg_d  = cap_load_q ? cap_wreg_q : 1'b0;
                    wdata_d = cap_load_q ? ld_ext : 32'b0;
                    state_d = ST_IDLE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    wd_d    = cap_wd_q;
                    wreg_d  = 1'b0;
                    wdata_d = 32'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cap_wd_q   <= 5'b0;
            cap_wreg_q <= 1'b0;
            cap_load_q <= 1'b0;
            cap_f3_q   <= 3'b0;
            cap_off_q  <= 2'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'b0;
            be_q       <= 4'b0;
            mwdata_q   <= 32'b0;
            valid_q    <= 1'b0;
            wd_q       <= 5'b0;
            wreg_q     <= 1'b0;
            wdata_q    <= 32'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_wd_q   <= cap_wd_d;
            cap_wreg_q <= cap_wreg_d;
            cap_load_q <= cap_load_d;
            cap_f3_q   <= cap_f3_d;
            cap_off_q  <= cap_off_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            mwdata_q   <= mwdata_d;
            valid_q    <= valid_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign stall_o      = (state_q == ST_WAIT);
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = mwdata_q;
    assign valid_o      = valid_q;
    assign wd_o         = wd_q;
    assign wreg_o       = wreg_q;
    assign wdata_o      = wdata_q;
    assign err_o        = err_q;

endmodule
